// File: rtl/wb_debug_bridge_pkg.sv
// Shared definitions for the byte-stream to Wishbone debug bridge:
// command layout, status codes and FSM state encoding.
package wb_debug_bridge_pkg;

  localparam int unsigned ADR_W = 32;
  localparam int unsigned DAT_W = 32;
  localparam int unsigned SEL_W = 4;

  // Command byte: we in bit 7, reserved bits 6:4 (must be zero), sel in 3:0
  typedef struct packed {
    logic             we;
    logic [2:0]       rsv;
    logic [SEL_W-1:0] sel;
  } cmd_t;

  localparam logic [7:0] STATUS_OK      = 8'h00;
  localparam logic [7:0] STATUS_BUS_ERR = 8'h01;
  localparam logic [7:0] STATUS_TIMEOUT = 8'h02;
  localparam logic [7:0] STATUS_BAD_CMD = 8'h03;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ADDR = 3'd1,
    ST_DATA = 3'd2,
    ST_BUS  = 3'd3,
    ST_RESP = 3'd4
  } state_t;

  function automatic logic cmd_bad(input cmd_t c);
    return (c.rsv != 3'b000) || (c.sel == '0);
  endfunction

endpackage

// File: rtl/wb_debug_bridge.sv
// Host byte-stream to classic Wishbone initiator: decodes command frames,
// runs one bus cycle per frame and streams back read data plus a status byte.
module wb_debug_bridge
  import wb_debug_bridge_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic             wb_clk_i,
  input  logic             wb_rstn_i,
  input  logic [7:0]       rx_dat_i,
  input  logic             rx_valid_i,
  output logic             rx_ready_o,
  output logic [7:0]       tx_dat_o,
  output logic             tx_valid_o,
  input  logic             tx_ready_i,
  output logic [ADR_W-1:0] wb_adr_o,
  output logic [DAT_W-1:0] wb_dat_o,
  input  logic [DAT_W-1:0] wb_dat_i,
  output logic             wb_we_o,
  output logic [SEL_W-1:0] wb_sel_o,
  output logic             wb_cyc_o,
  output logic             wb_stb_o,
  input  logic             wb_ack_i,
  input  logic             wb_err_i,
  output logic             busy_o
);

  localparam int unsigned TMO_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  state_t           state_q, state_n;
  logic [1:0]       cnt_q, cnt_n;
  logic [ADR_W-1:0] adr_q, adr_n;
  logic [DAT_W-1:0] dat_q, dat_n;
  logic [DAT_W-1:0] rdata_q, rdata_n;
  logic             we_q, we_n;
  logic [SEL_W-1:0] sel_q, sel_n;
  logic [7:0]       status_q, status_n;
  logic             resp_data_q, resp_data_n;
  logic [TMO_W-1:0] tmo_q, tmo_n;
  logic [7:0]       tx_dat_n;
  logic             cyc_q, rx_ready_q, tx_valid_q, busy_q;
  logic             rx_fire, tx_fire, tmo_hit;
  cmd_t             cmd;

  assign cmd     = cmd_t'(rx_dat_i);
  assign rx_fire = rx_valid_i & rx_ready_q;
  assign tx_fire = tx_valid_q & tx_ready_i;
  assign tmo_hit = (TIMEOUT_CYCLES != 0) && (tmo_q == TMO_LAST);

  // Next-state and datapath decode
  always_comb begin
    state_n     = state_q;
    cnt_n       = cnt_q;
    adr_n       = adr_q;
    dat_n       = dat_q;
    rdata_n     = rdata_q;
    we_n        = we_q;
    sel_n       = sel_q;
    status_n    = status_q;
    resp_data_n = resp_data_q;
    tmo_n       = tmo_q;
    tx_dat_n    = 8'h00;

    unique case (state_q)
      ST_IDLE: begin
        if (rx_fire) begin
          cnt_n = 2'd0;
          if (cmd_bad(cmd)) begin
            status_n    = STATUS_BAD_CMD;
            resp_data_n = 1'b0;
            state_n     = ST_RESP;
          end else begin
            we_n    = cmd.we;
            sel_n   = cmd.sel;
            state_n = ST_ADDR;
          end
        end
      end
      ST_ADDR: begin
        if (rx_fire) begin
          adr_n = {rx_dat_i, adr_q[ADR_W-1:8]};
          cnt_n = cnt_q + 2'd1;
          if (cnt_q == 2'd3) state_n = we_q ? ST_DATA : ST_BUS;
        end
      end
      ST_DATA: begin
        if (rx_fire) begin
          dat_n = {rx_dat_i, dat_q[DAT_W-1:8]};
          cnt_n = cnt_q + 2'd1;
          if (cnt_q == 2'd3) state_n = ST_BUS;
        end
      end
      ST_BUS: begin
        tmo_n = (tmo_q == {TMO_W{1'b1}}) ? tmo_q : tmo_q + TMO_W'(1);
        // err outranks ack, which outranks timeout
        if (wb_err_i) begin
          status_n    = STATUS_BUS_ERR;
          rdata_n     = '0;
          resp_data_n = ~we_q;
          state_n     = ST_RESP;
        end else if (wb_ack_i) begin
          status_n    = STATUS_OK;
          rdata_n     = wb_dat_i;
          resp_data_n = ~we_q;
          state_n     = ST_RESP;
        end else if (tmo_hit) begin
          status_n    = STATUS_TIMEOUT;
          rdata_n     = '0;
          resp_data_n = ~we_q;
          state_n     = ST_RESP;
        end
      end
      ST_RESP: begin
        if (tx_fire) begin
          if (resp_data_q) begin
            cnt_n = cnt_q + 2'd1;
            if (cnt_q == 2'd3) resp_data_n = 1'b0;
          end else begin
            state_n = ST_IDLE;
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase

    if ((state_n == ST_BUS) && (state_q != ST_BUS)) tmo_n = '0;

    // TX byte is precomputed so it is valid on the first RESP cycle
    if (state_n == ST_RESP)
      tx_dat_n = resp_data_n ? rdata_n[{cnt_n, 3'b000} +: 8] : status_n;
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rstn_i) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      adr_q       <= '0;
      dat_q       <= '0;
      rdata_q     <= '0;
      we_q        <= 1'b0;
      sel_q       <= '0;
      status_q    <= '0;
      resp_data_q <= 1'b0;
      tmo_q       <= '0;
      tx_dat_o    <= '0;
      cyc_q       <= 1'b0;
      rx_ready_q  <= 1'b0;
      tx_valid_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_n;
      cnt_q       <= cnt_n;
      adr_q       <= adr_n;
      dat_q       <= dat_n;
      rdata_q     <= rdata_n;
      we_q        <= we_n;
      sel_q       <= sel_n;
      status_q    <= status_n;
      resp_data_q <= resp_data_n;
      tmo_q       <= tmo_n;
      tx_dat_o    <= tx_dat_n;
      cyc_q       <= (state_n == ST_BUS);
      rx_ready_q  <= (state_n == ST_IDLE) || (state_n == ST_ADDR) || (state_n == ST_DATA);
      tx_valid_q  <= (state_n == ST_RESP);
      busy_q      <= (state_n != ST_IDLE);
    end
  end

  assign rx_ready_o = rx_ready_q;
  assign tx_valid_o = tx_valid_q;
  assign busy_o     = busy_q;
  assign wb_cyc_o   = cyc_q;
  assign wb_stb_o   = cyc_q;
  assign wb_adr_o   = adr_q;
  assign wb_dat_o   = dat_q;
  assign wb_we_o    = we_q;
  assign wb_sel_o   = sel_q;

endmodule

// File: tb/tb_wb_debug_bridge.sv
// Directed bench for wb_debug_bridge: host frames in, bus cycles and
// response bytes checked against hand-computed values.
module tb_wb_debug_bridge;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [7:0]  rx_dat = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic [7:0]  tx_dat;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic [31:0] wb_adr, wb_dat_w;
  logic [31:0] wb_dat_r = 32'h0;
  logic        wb_we, wb_cyc, wb_stb, wb_ack, wb_err, busy;
  logic [3:0]  wb_sel;

  // slave model controls (written by the stimulus only)
  int   lat = 1;
  logic ack_en = 1'b1;
  logic err_en = 1'b0;
  logic late_ack = 1'b0;

  // slave model state (written by the slave process only)
  logic        slv_ack = 1'b0, slv_err = 1'b0;
  int          bus_n = 0, last_len = 0, total_cyc = 0;
  logic [31:0] cap_adr = 32'h0, cap_dat = 32'h0;
  logic        cap_we = 1'b0, stable = 1'b1;
  logic [3:0]  cap_sel = 4'h0;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  assign wb_ack = slv_ack | late_ack;
  assign wb_err = slv_err;

  wb_debug_bridge #(.TIMEOUT_CYCLES(8)) dut (
    .wb_clk_i  (clk),
    .wb_rstn_i (rstn),
    .rx_dat_i  (rx_dat),
    .rx_valid_i(rx_valid),
    .rx_ready_o(rx_ready),
    .tx_dat_o  (tx_dat),
    .tx_valid_o(tx_valid),
    .tx_ready_i(tx_ready),
    .wb_adr_o  (wb_adr),
    .wb_dat_o  (wb_dat_w),
    .wb_dat_i  (wb_dat_r),
    .wb_we_o   (wb_we),
    .wb_sel_o  (wb_sel),
    .wb_cyc_o  (wb_cyc),
    .wb_stb_o  (wb_stb),
    .wb_ack_i  (wb_ack),
    .wb_err_i  (wb_err),
    .busy_o    (busy)
  );

  // Wishbone slave: responds on the lat-th cycle of cyc, records what it saw
  always @(negedge clk) begin
    if (wb_cyc) begin
      bus_n = bus_n + 1;
      total_cyc = total_cyc + 1;
      if (bus_n == 1) begin
        cap_adr = wb_adr; cap_dat = wb_dat_w; cap_we = wb_we; cap_sel = wb_sel;
        stable = (wb_stb === 1'b1);
      end else if (wb_adr !== cap_adr || wb_dat_w !== cap_dat || wb_we !== cap_we ||
                   wb_sel !== cap_sel || wb_stb !== 1'b1) begin
        stable = 1'b0;
      end
      slv_ack = ack_en && (bus_n == lat);
      slv_err = err_en && (bus_n == lat);
    end else begin
      if (bus_n != 0) last_len = bus_n;
      bus_n = 0;
      slv_ack = 1'b0;
      slv_err = 1'b0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    rx_dat = b;
    rx_valid = 1'b1;
    while (!rx_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("rx_ready_wait", 32'(rx_ready), 32'(1'b1));
    @(posedge clk);
    #1 rx_valid = 1'b0;
  endtask

  task automatic recv_byte(input string tag, input logic [7:0] exp);
    int n = 0;
    @(negedge clk);
    tx_ready = 1'b1;
    while (!tx_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_valid"}, 32'(tx_valid), 32'(1'b1));
    check(tag, 32'(tx_dat), 32'(exp));
    @(posedge clk);
    #1 tx_ready = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] cmd, input logic [31:0] adr, input logic [31:0] dat);
    send_byte(cmd);
    for (int i = 0; i < 4; i++) send_byte(adr[8*i +: 8]);
    if (cmd[7]) for (int i = 0; i < 4; i++) send_byte(dat[8*i +: 8]);
  endtask

  task automatic expect_resp(input string tag, input logic has_data, input logic [31:0] d,
                             input logic [7:0] st);
    if (has_data) for (int i = 0; i < 4; i++) recv_byte($sformatf("%s_d%0d", tag, i), d[8*i +: 8]);
    recv_byte({tag, "_status"}, st);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] held;
    logic       bp_ok;
    int         t0;
    int         n;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ctrl", 32'({rx_ready, tx_valid, wb_cyc, wb_stb, wb_we, busy}), 32'h0);
    check("rst_adr", wb_adr, 32'h0);
    check("rst_dat_sel_tx", 32'({wb_sel, tx_dat}), 32'h0);
    rstn = 1'b1;
    @(negedge clk);
    check("idle_rx_ready", 32'(rx_ready), 32'(1'b1));

    // 1: write, same-cycle ack
    lat = 1; ack_en = 1'b1; err_en = 1'b0;
    send_frame(8'h8F, 32'h10010000, 32'hDEADBEEF);
    expect_resp("wr", 1'b0, 32'h0, 8'h00);
    check("wr_adr", cap_adr, 32'h10010000);
    check("wr_dat", cap_dat, 32'hDEADBEEF);
    check("wr_we_sel", 32'({cap_we, cap_sel}), 32'h1F);
    check("wr_len", 32'(last_len), 32'd1);
    check("wr_stable", 32'(stable), 32'(1'b1));

    // 2: read, ack in the 4th bus cycle
    lat = 4; wb_dat_r = 32'hCAFEF00D;
    send_frame(8'h03, 32'h10010004, 32'h0);
    expect_resp("rd", 1'b1, 32'hCAFEF00D, 8'h00);
    check("rd_adr", cap_adr, 32'h10010004);
    check("rd_we_sel", 32'({cap_we, cap_sel}), 32'h03);
    check("rd_len", 32'(last_len), 32'd4);
    check("rd_stable", 32'(stable), 32'(1'b1));

    // 3: err and ack together -> err wins, data zeroed
    lat = 2; err_en = 1'b1; wb_dat_r = 32'h12345678;
    send_frame(8'h0F, 32'h00000020, 32'h0);
    expect_resp("err", 1'b1, 32'h0, 8'h01);
    check("err_len", 32'(last_len), 32'd2);
    err_en = 1'b0;

    // 4: timeout on a write, late ack during response ignored
    ack_en = 1'b0;
    send_frame(8'h81, 32'h00000044, 32'h11223344);
    n = 0;
    while (!tx_valid && n < 100) begin @(negedge clk); n++; end
    late_ack = 1'b1;
    repeat (2) @(negedge clk);
    late_ack = 1'b0;
    check("tmo_hold_busy", 32'(busy), 32'(1'b1));
    check("tmo_hold_tx", 32'(tx_dat), 32'h02);
    expect_resp("tmo", 1'b0, 32'h0, 8'h02);
    check("tmo_len", 32'(last_len), 32'd8);
    ack_en = 1'b1;

    // 5: bad commands, one byte each, no bus access
    t0 = total_cyc;
    send_byte(8'h90);
    @(negedge clk);
    check("bad_rx_blocked", 32'({rx_ready, busy}), 32'h1);
    expect_resp("bad90", 1'b0, 32'h0, 8'h03);
    send_byte(8'h40);
    expect_resp("bad40", 1'b0, 32'h0, 8'h03);
    send_byte(8'h80);
    expect_resp("bad_sel0", 1'b0, 32'h0, 8'h03);
    check("bad_no_cyc", 32'(total_cyc - t0), 32'd0);
    @(negedge clk);
    check("bad_idle", 32'({rx_ready, busy}), 32'h2);

    // 6a: TX backpressure during read response
    lat = 1; wb_dat_r = 32'h89ABCDEF;
    send_frame(8'h0F, 32'h00000030, 32'h0);
    recv_byte("bp_d0", 8'hEF);
    @(negedge clk);
    held = tx_dat;
    bp_ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (tx_valid !== 1'b1 || tx_dat !== 8'hCD) bp_ok = 1'b0;
    end
    check("bp_stable", 32'({bp_ok, held}), 32'h1CD);
    recv_byte("bp_d1", 8'hCD);
    recv_byte("bp_d2", 8'hAB);
    recv_byte("bp_d3", 8'h89);
    recv_byte("bp_status", 8'h00);

    // 6b: reset while in BUS, then a clean frame
    ack_en = 1'b0;
    send_frame(8'h01, 32'h00000040, 32'h0);
    n = 0;
    while (!wb_cyc && n < 20) begin @(negedge clk); n++; end
    check("rstbus_cyc_seen", 32'(wb_cyc), 32'(1'b1));
    @(negedge clk);
    rstn = 1'b0;
    @(posedge clk);
    #1;
    check("rstbus_out", 32'({wb_cyc, wb_stb, tx_valid, rx_ready, busy}), 32'h0);
    @(negedge clk);
    rstn = 1'b1;
    lat = 2; ack_en = 1'b1;
    send_frame(8'h85, 32'h00000050, 32'h0000A5A5);
    expect_resp("post_rst", 1'b0, 32'h0, 8'h00);
    check("post_rst_adr", cap_adr, 32'h00000050);
    check("post_rst_dat", cap_dat, 32'h0000A5A5);
    check("post_rst_sel", 32'({cap_we, cap_sel}), 32'h15);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
